// File: rtl/spi_pkg.sv
// Shared SPI definitions: shifter state encoding and command codes.
// Also imported by the command/select state machine.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

  localparam logic [3:0] SPI_RD = 4'h1;
  localparam logic [3:0] SPI_WR = 4'h2;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings sclk, cs_n and mosi into the clk domain through two-flop
// synchronisers. One extra flop on sclk provides rise/fall detection.
// mosi and cs_n share the same two-flop latency as sclk. Because of that,
// a synchronised mosi sampled on a detected rise still lines up with the pin edge.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic rise,
  output logic fall,
  output logic level,
  output logic cs_n_s,
  output logic mosi_s
);

  logic sclk_s1, sclk_s2, sclk_d;
  logic cs_s1, cs_s2;
  logic mosi_s1, mosi_s2;

  // Synchroniser chains plus the sclk history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign rise   = sclk_s2 & ~sclk_d;
  assign fall   = ~sclk_s2 & sclk_d;
  assign level  = sclk_s2;
  assign cs_n_s = cs_s2;
  assign mosi_s = mosi_s2;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave shifter, oversampled by clk (>= 4x sclk).
// Optional overrun detection is enabled by defining SPI_OVERRUN_EN.
//
// state | meaning
// IDLE  | cs_n high, or no fresh frame since reset; miso held at 0
// SHIFT | shifting bits of the current unit
// DONE  | one-clk completion cycle; done=1 and tx_data is reloaded on exit
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             byte_ack,
  output logic [WIDTH-1:0] rx_data,
  output logic [CMD_W-1:0] cmd,
  output logic             done,
  output logic             overrun
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic rise, fall, cs_s, mosi_s, sclk_level_unused;

  spi_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .rise   (rise),
    .fall   (fall),
    .level  (sclk_level_unused),
    .cs_n_s (cs_s),
    .mosi_s (mosi_s)
  );

  spi_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             armed_q;

  // The synchronised cs_n clears to 0 (looks selected) on reset.
  // armed_q blocks IDLE->SHIFT until cs_n has been seen high, so reception
  // only restarts on a fresh frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       armed_q <= 1'b0;
    else if (cs_s) armed_q <= 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      rx_data_q <= rx_data_d;
    end
  end

  // Next-state and datapath update. A completing rise wins over cs_n high.
  // The fall that follows the last rise of a unit finds cnt_q == 0. It is
  // ignored so the freshly reloaded MSB stays on miso.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    rx_data_d = rx_data_q;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && !cs_s) begin
          state_d = SHIFT;
          cnt_d   = '0;
          tx_sr_d = tx_data;
        end
      end
      SHIFT: begin
        if (rise && cnt_q == LAST) begin
          state_d   = DONE;
          rx_sr_d   = {rx_sr_q[WIDTH-2:0], mosi_s};
          rx_data_d = {rx_sr_q[WIDTH-2:0], mosi_s};
        end else if (cs_s) begin
          state_d = IDLE;
        end else if (rise) begin
          rx_sr_d = {rx_sr_q[WIDTH-2:0], mosi_s};
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (fall && cnt_q != '0) begin
          tx_sr_d = tx_sr_q << 1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (cs_s) begin
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
          cnt_d   = '0;
          tx_sr_d = tx_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso    = (state_q != IDLE) & tx_sr_q[WIDTH-1];
  assign rx_data = rx_data_q;
  assign cmd     = rx_data_q[WIDTH-1 -: CMD_W];

`ifdef SPI_OVERRUN_EN
  logic pending_q, overrun_q;

  // Unacked-unit tracking; an ack in the completion cycle still leaves
  // the new unit pending without flagging an overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (done) begin
      if (pending_q && !byte_ack) overrun_q <= 1'b1;
      pending_q <= 1'b1;
    end else if (byte_ack) begin
      pending_q <= 1'b0;
    end
  end

  assign overrun = overrun_q;
`else
  logic byte_ack_unused;
  assign byte_ack_unused = byte_ack;
  assign overrun         = 1'b0;
`endif

endmodule

// File: doc/spi_slave_shifter.md
SPI_SLAVE_SHIFTER -- requirements
Module: spi_slave_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per SPI transfer unit.
REQ-002 SHALL have parameter CMD_W, default 4, width of the command field taken from the received unit's MSBs.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sclk, input, 1, SPI serial clock from the master, asynchronous to clk.
REQ-006 SHALL have port cs_n, input, 1, SPI chip select, active low, asynchronous.
REQ-007 SHALL have port mosi, input, 1, master-out serial data, asynchronous.
REQ-008 SHALL have port miso, output, 1, slave-out serial data.
REQ-009 SHALL have port tx_data, input, WIDTH, next unit to transmit, sampled at unit boundary.
REQ-010 SHALL have port byte_ack, input, 1, consumer acknowledge of rx_data.
REQ-011 SHALL have port rx_data, output, WIDTH, last complete received unit.
REQ-012 SHALL have port cmd, output, CMD_W, equal to rx_data[WIDTH-1:WIDTH-CMD_W].
REQ-013 SHALL have port done, output, 1, single-cycle pulse on unit completion; feeds the command/select state machine.
REQ-014 SHALL have port overrun, output, 1, sticky overrun flag.

Function
REQ-015 SHALL operate in SPI mode 0: mosi sampled on sclk rising, miso changed on sclk falling, MSB first.
REQ-016 SHALL synchronise sclk, cs_n and mosi through two flops each, plus one flop on sclk for edge detection.
REQ-017 SHALL support clk frequency >= 4x sclk; slower clk is out of scope.
REQ-018 SHALL implement states IDLE, SHIFT, DONE.
REQ-019 IDLE -> SHIFT when synchronised cs_n is low; bit counter cleared; tx_data loaded into the tx shift register.
REQ-020 In SHIFT, each detected sclk rise SHALL shift synchronised mosi into the rx register LSB and increment the bit counter.
REQ-021 The WIDTH-th rise SHALL go SHIFT -> DONE and copy the rx register to rx_data.
REQ-022 DONE SHALL last exactly one clk with done=1, then return to SHIFT with the counter wrapped to 0 and tx_data reloaded.
REQ-023 cmd and rx_data SHALL hold until the next DONE.
REQ-024 done SHALL rise within 4 clk of the WIDTH-th sclk pin rise.
REQ-025 Each detected sclk fall in SHIFT SHALL shift the tx register left; miso = tx register MSB.
REQ-026 cs_n high in any state SHALL force IDLE next cycle, discard the partial unit and hold rx_data; no done is produced.
REQ-027 If cs_n rises in the same cycle as the WIDTH-th rise, the unit SHALL complete and done SHALL pulse.
REQ-028 miso SHALL be 0 while in IDLE.
REQ-029 Back-to-back units within one cs_n frame SHALL each produce exactly one done.

Reset
REQ-030 rst SHALL asynchronously force IDLE, clear all synchroniser flops and set the counter to 0.
REQ-031 rst SHALL set rx_data=0, cmd=0, done=0, miso=0 and overrun=0.
REQ-032 rst asserted mid-unit SHALL discard the unit; after release, reception restarts only on a fresh cs_n-low frame.

Configuration
REQ-033 Macro SPI_OVERRUN_EN SHALL control overrun detection.
REQ-034 With SPI_OVERRUN_EN defined, an unacked-pending flag SHALL be set on done and cleared on byte_ack.
REQ-035 With SPI_OVERRUN_EN defined, done while the pending flag is set SHALL set overrun, which is cleared only by rst.
REQ-036 With SPI_OVERRUN_EN defined, byte_ack and done in the same cycle SHALL leave the flag set and SHALL NOT raise overrun.
REQ-037 Without SPI_OVERRUN_EN, overrun SHALL be tied to 0 and byte_ack ignored.

Structure
REQ-038 State encodings and the SPI_RD/SPI_WR command code constants SHALL reside in the shared package spi_pkg, also used by the command state machine.
REQ-039 The synchroniser and edge detector SHALL be a sub-module spi_sync_edge, with outputs rise, fall and level.

Verification
REQ-040 cs_n low, 8 sclk at clk/8, mosi 0xA5 -> one done pulse, rx_data=0xA5, cmd=0xA.
REQ-041 tx_data=0x3C at cs_n fall, 8 sclk -> miso bits 0,0,1,1,1,1,0,0 sampled on sclk rises.
REQ-042 Two back-to-back units 0x1F, 0x20 in one frame -> two done pulses, final rx_data=0x20.
REQ-043 cs_n raised after 5 bits -> no done, rx_data unchanged; next full unit 0x81 received correctly.
REQ-044 With SPI_OVERRUN_EN: two units with no byte_ack -> overrun=1 after the second done; acked run -> overrun stays 0.
REQ-045 rst pulsed after bit 3 -> all outputs 0 immediately; next frame 0x55 -> rx_data=0x55.
